// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 memory-access sequencer with a variable-latency ack handshake.
// Drives the MDR load strobe on reads and reports a timeout via err_o.
module lc3_mem_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  err_o,
    output logic                  mdr_wr_en_o,
    output logic [DATA_WIDTH-1:0] mdr_d_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    // Count value in the last ACCESS cycle allowed before aborting.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
    state_t state, state_n;
    logic [7:0] cnt, cnt_n;
    logic ready_n, err_n, wr_n, en_n, we_n;
    logic [DATA_WIDTH-1:0] d_n, wdata_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ready_o     <= 1'b0;
            err_o       <= 1'b0;
            mdr_wr_en_o <= 1'b0;
            mdr_d_o     <= '0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ready_o     <= ready_n;
            err_o       <= err_n;
            mdr_wr_en_o <= wr_n;
            mdr_d_o     <= d_n;
            mem_en_o    <= en_n;
            mem_we_o    <= we_n;
            mem_addr_o  <= addr_n;
            mem_wdata_o <= wdata_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready_n = 1'b0;
        err_n   = 1'b0;
        wr_n    = 1'b0;
        d_n     = mdr_d_o;
        en_n    = mem_en_o;
        we_n    = mem_we_o;
        addr_n  = mem_addr_o;
        wdata_n = mem_wdata_o;
        case (state)
            IDLE: if (req_i) begin
                state_n = ACCESS;
                cnt_n   = '0;
                en_n    = 1'b1;
                we_n    = we_i;
                addr_n  = addr_i;
                wdata_n = wdata_i;
            end
            ACCESS: if (mem_ack_i) begin
                state_n = DONE;
                en_n    = 1'b0;
                ready_n = 1'b1;
                wr_n    = ~mem_we_o;
                d_n     = mem_we_o ? mdr_d_o : mem_rdata_i;
            end else if (TIMEOUT != 0) begin
                // An ack in the limit cycle is handled above, so it beats the timeout.
                if (cnt == LIMIT) begin
                    state_n = DONE;
                    en_n    = 1'b0;
                    ready_n = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: two controllers (TIMEOUT=8 and TIMEOUT=0) share one stimulus stream;
// a transaction-level model predicts every output and directed literals pin the model.
module tb_lc3_mem_ctrl;
    localparam int TOL [2] = '{8, 0};
    logic clk = 1'b0;
    logic rst, req, we, ack;
    logic [15:0] addr, wdata, rdata;
    logic ready [2], err [2], mwr [2], en [2], mwe [2];
    logic [15:0] mdr [2], maddr [2], mwdata [2];
    int n_cmp = 0, n_bad = 0;
    int rdy_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    int en_cyc [2] = '{0, 0};
    always #5 clk = ~clk;

    lc3_mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(8)) u0 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready[0]), .err_o(err[0]), .mdr_wr_en_o(mwr[0]), .mdr_d_o(mdr[0]),
        .mem_en_o(en[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]),
        .mem_rdata_i(rdata), .mem_ack_i(ack));
    lc3_mem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(0)) u1 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready[1]), .err_o(err[1]), .mdr_wr_en_o(mwr[1]), .mdr_d_o(mdr[1]),
        .mem_en_o(en[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]),
        .mem_rdata_i(rdata), .mem_ack_i(ack));

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Transaction model: busy = an access is open, waited = ACCESS cycles elapsed,
    // rest = the one mandatory turnaround cycle after completion.
    logic m_ready [2], m_err [2], m_wr [2], m_en [2], m_we [2];
    logic [15:0] m_d [2], m_addr [2], m_wdata [2];
    bit busy [2], rest [2];
    int waited [2];
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            m_ready[i] <= 1'b0;
            m_err[i]   <= 1'b0;
            m_wr[i]    <= 1'b0;
            if (rst) begin
                m_en[i] <= 1'b0; m_we[i] <= 1'b0; m_d[i] <= '0; m_addr[i] <= '0; m_wdata[i] <= '0;
                busy[i] <= 1'b0; rest[i] <= 1'b0; waited[i] <= 0;
            end else if (busy[i]) begin
                waited[i] <= waited[i] + 1;
                if (ack) begin
                    busy[i] <= 1'b0; rest[i] <= 1'b1; m_en[i] <= 1'b0; m_ready[i] <= 1'b1;
                    if (!m_we[i]) begin
                        m_wr[i] <= 1'b1;
                        m_d[i]  <= rdata;
                    end
                end else if (TOL[i] != 0 && waited[i] + 1 == TOL[i]) begin
                    busy[i] <= 1'b0; rest[i] <= 1'b1; m_en[i] <= 1'b0;
                    m_ready[i] <= 1'b1; m_err[i] <= 1'b1;
                end
            end else if (rest[i]) begin
                rest[i] <= 1'b0;
            end else if (req) begin
                busy[i] <= 1'b1; waited[i] <= 0; m_en[i] <= 1'b1;
                m_we[i] <= we; m_addr[i] <= addr; m_wdata[i] <= wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.ready_o", i), 32'(ready[i]), 32'(m_ready[i]));
                chk($sformatf("u%0d.err_o", i), 32'(err[i]), 32'(m_err[i]));
                chk($sformatf("u%0d.mdr_wr_en_o", i), 32'(mwr[i]), 32'(m_wr[i]));
                chk($sformatf("u%0d.mdr_d_o", i), 32'(mdr[i]), 32'(m_d[i]));
                chk($sformatf("u%0d.mem_en_o", i), 32'(en[i]), 32'(m_en[i]));
                chk($sformatf("u%0d.mem_we_o", i), 32'(mwe[i]), 32'(m_we[i]));
                chk($sformatf("u%0d.mem_addr_o", i), 32'(maddr[i]), 32'(m_addr[i]));
                chk($sformatf("u%0d.mem_wdata_o", i), 32'(mwdata[i]), 32'(m_wdata[i]));
                rdy_cnt[i] <= rdy_cnt[i] + int'(ready[i]);
                err_cnt[i] <= err_cnt[i] + int'(err[i]);
                en_cyc[i]  <= en_cyc[i] + int'(en[i]);
            end
        end
    end

    task automatic drv(input logic r, input logic w, input logic [15:0] a, input logic [15:0] wd,
                       input logic k, input logic [15:0] rd);
        req = r; we = w; addr = a; wdata = wd; ack = k; rdata = rd;
        @(negedge clk);
        #1;
    endtask

    int r0, r1, e0, e1, c0;
    initial begin
        rst = 1'b1; req = 0; we = 0; addr = 0; wdata = 0; ack = 0; rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.mem_en", 32'(en[0]), 0);
        chk("rst.ready", 32'(ready[1]), 0);
        chk("rst.mdr_d", 32'(mdr[0]), 0);
        chk("rst.mem_addr", 32'(maddr[1]), 0);
        rst = 1'b0;
        // read, ack in the first ACCESS cycle
        c0 = en_cyc[0];
        drv(1, 0, 16'h3000, 16'h0, 0, 16'h0);
        chk("t1.mem_en", 32'(en[0]), 1);
        chk("t1.mem_addr", 32'(maddr[0]), 32'h3000);
        drv(0, 0, 16'h0, 16'h0, 1, 16'h1234);
        chk("t1.ready", 32'(ready[0]), 1);
        chk("t1.mdr_wr_en", 32'(mwr[1]), 1);
        chk("t1.mdr_d", 32'(mdr[0]), 32'h1234);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        chk("t1.ready_drop", 32'(ready[0]), 0);
        chk("t1.en_cycles", 32'(en_cyc[0] - c0), 1);
        // write, ack after 4 wait cycles, addr_i wiggled meanwhile
        c0 = en_cyc[0]; r0 = rdy_cnt[0];
        drv(1, 1, 16'hFE06, 16'h0041, 0, 16'h0);
        for (int k = 0; k < 4; k++) drv(0, 0, 16'h1111 + 16'(k), 16'h9999, 0, 16'hDEAD);
        chk("t2.mem_addr", 32'(maddr[0]), 32'hFE06);
        chk("t2.mem_wdata", 32'(mwdata[1]), 32'h0041);
        drv(0, 0, 16'h0, 16'h0, 1, 16'hDEAD);
        chk("t2.mdr_wr_en", 32'(mwr[0]), 0);
        chk("t2.mdr_d_kept", 32'(mdr[0]), 32'h1234);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        chk("t2.en_cycles", 32'(en_cyc[0] - c0), 5);
        chk("t2.ready_pulses", 32'(rdy_cnt[0] - r0), 1);
        // timeout after 8 ACCESS cycles on u0; u1 waits, then a stray ack hits idle u0
        c0 = en_cyc[0]; r0 = rdy_cnt[0];
        drv(1, 0, 16'h4000, 16'h0, 0, 16'h0);
        for (int k = 0; k < 8; k++) drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        chk("t3.ready", 32'(ready[0]), 1);
        chk("t3.err", 32'(err[0]), 1);
        chk("t3.mdr_wr_en", 32'(mwr[0]), 0);
        chk("t3.u1_still_en", 32'(en[1]), 1);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        drv(0, 0, 16'h0, 16'h0, 1, 16'hABCD);
        chk("t3.stray_ack", 32'(ready[0]), 0);
        chk("t3.u1_mdr", 32'(mdr[1]), 32'hABCD);
        chk("t3.u0_mdr_kept", 32'(mdr[0]), 32'h1234);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        chk("t3.en_cycles", 32'(en_cyc[0] - c0), 8);
        chk("t3.ready_pulses", 32'(rdy_cnt[0] - r0), 1);
        // ack in the limit cycle wins over the timeout
        drv(1, 0, 16'h4001, 16'h0, 0, 16'h0);
        for (int k = 0; k < 7; k++) drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        drv(0, 0, 16'h0, 16'h0, 1, 16'h5555);
        chk("t3b.ready", 32'(ready[0]), 1);
        chk("t3b.err", 32'(err[0]), 0);
        chk("t3b.mdr", 32'(mdr[0]), 32'h5555);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        // req and ack held high: one access every 3 cycles
        r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
        for (int k = 0; k < 9; k++) drv(1, 0, 16'h2000 + 16'(k), 16'h0, 1, 16'h0100 + 16'(k));
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        chk("t4.u0_pulses", 32'(rdy_cnt[0] - r0), 3);
        chk("t4.u1_pulses", 32'(rdy_cnt[1] - r1), 3);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        // async reset in the middle of ACCESS
        r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
        drv(1, 0, 16'h5000, 16'h0, 0, 16'h0);
        req = 0;
        #2 rst = 1'b1;
        #1;
        chk("t5.u0_en_now", 32'(en[0]), 0);
        chk("t5.u1_en_now", 32'(en[1]), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) drv(0, 0, 16'h0, 16'h0, 1, 16'h0);
        chk("t5.no_ready", 32'(rdy_cnt[0] - r0 + rdy_cnt[1] - r1), 0);
        drv(1, 0, 16'h5001, 16'h0, 0, 16'h0);
        drv(0, 0, 16'h0, 16'h0, 1, 16'h7777);
        chk("t5.restart_ready", 32'(ready[1]), 1);
        chk("t5.restart_mdr", 32'(mdr[0]), 32'h7777);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        // ack 300 cycles late: u1 (no timeout) loads it, u0 has long since timed out
        e0 = err_cnt[0]; e1 = err_cnt[1];
        drv(1, 0, 16'h6000, 16'h0, 0, 16'h0);
        for (int k = 0; k < 299; k++) drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        drv(0, 0, 16'h0, 16'h0, 1, 16'hBEEF);
        chk("t6.u1_ready", 32'(ready[1]), 1);
        chk("t6.u1_err", 32'(err[1]), 0);
        chk("t6.u1_mdr", 32'(mdr[1]), 32'hBEEF);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        drv(0, 0, 16'h0, 16'h0, 0, 16'h0);
        chk("t6.u0_errs", 32'(err_cnt[0] - e0), 1);
        chk("t6.u1_errs", 32'(err_cnt[1] - e1), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
